// File: rtl/spi_ram_sync.sv
// SPI mode-0 RAM peripheral that runs entirely on the system clock. The SPI
// pins are oversampled and edge-detected, and the RAM is a register array.
module spi_ram_sync #(
  parameter int RAM_LEN_BITS = 5,
  parameter int ADDR_BYTES   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  input  logic                    spi_select,
  output logic                    spi_miso,
  input  logic [RAM_LEN_BITS-1:0] addr_in,
  output logic [7:0]              byte_out,
  input  logic                    wr_en,
  input  logic [7:0]              data_in,
  input  logic                    clear_dirty,
  output logic                    spi_wr_valid,
  output logic [RAM_LEN_BITS-1:0] spi_wr_addr,
  output logic                    dirty
);

  localparam int         DEPTH      = 1 << RAM_LEN_BITS;
  localparam logic [4:0] ADDR_LAST  = 5'(ADDR_BYTES * 8 - 1);
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;
  localparam logic [7:0] CMD_FAST   = 8'h0B;

  typedef enum logic [2:0] {
    ST_WAIT_DESEL,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD,
    ST_WR,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  state_t state;
  state_t state_next;

  // Pin synchronisers; index 0 is the first flop. Third spi_clk copy feeds
  // the edge detect, and mosi gets a matching third stage to stay aligned.
  logic [2:0] clk_sync;
  logic [2:0] mosi_sync;
  logic [1:0] sel_sync;
  logic [1:0] fill;
  logic       rise;
  logic       fall;

  logic [7:0]              mem [DEPTH];
  logic [4:0]              bit_cnt;
  logic [6:0]              shift;
  logic [7:0]              cmd;
  logic [RAM_LEN_BITS-1:0] ptr;
  logic [RAM_LEN_BITS-1:0] ptr_inc;
  logic [7:0]              tx_sh;
  logic [2:0]              tx_cnt;
  logic                    miso_q;

  logic [7:0] in_byte;
  logic       deselect;
  logic       cmd_done;
  logic       addr_done;
  logic       dummy_done;
  logic       commit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync  <= '0;
      mosi_sync <= '0;
      sel_sync  <= '1;
      fill      <= '0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], spi_clk};
      mosi_sync <= {mosi_sync[1:0], spi_mosi};
      sel_sync  <= {sel_sync[0], spi_select};
      fill      <= {fill[0], 1'b1};
      rise      <= clk_sync[1] & ~clk_sync[2];
      fall      <= ~clk_sync[1] & clk_sync[2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_WAIT_DESEL;
    else        state <= state_next;
  end

  // fill[1] marks that sel_sync holds real pin samples rather than reset
  // values, so a select held low across reset is never mistaken for a deselect.
  always_comb begin
    in_byte    = {shift, mosi_sync[2]};
    deselect   = sel_sync[1];
    ptr_inc    = ptr + RAM_LEN_BITS'(1);
    cmd_done   = 1'b0;
    addr_done  = 1'b0;
    dummy_done = 1'b0;
    commit     = 1'b0;
    state_next = state;
    if (state == ST_WAIT_DESEL) begin
      if (fill[1] && deselect) state_next = ST_CMD;
    end else if (deselect) begin
      state_next = ST_CMD;
    end else if (rise) begin
      case (state)
        ST_CMD: begin
          if (bit_cnt == 5'd7) begin
            cmd_done = 1'b1;
            case (in_byte)
              CMD_READ, CMD_WRITE, CMD_FAST: state_next = ST_ADDR;
              CMD_STATUS:                    state_next = ST_STATUS;
              default:                       state_next = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (bit_cnt == ADDR_LAST) begin
            addr_done = 1'b1;
            if (cmd == CMD_FAST)      state_next = ST_DUMMY;
            else if (cmd == CMD_READ) state_next = ST_RD;
            else                      state_next = ST_WR;
          end
        end
        ST_DUMMY: begin
          if (bit_cnt == 5'd7) begin
            dummy_done = 1'b1;
            state_next = ST_RD;
          end
        end
        ST_WR: begin
          if (bit_cnt == 5'd7) commit = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shift        <= '0;
      cmd          <= '0;
      ptr          <= '0;
      tx_sh        <= '0;
      tx_cnt       <= '0;
      miso_q       <= 1'b0;
      spi_wr_valid <= 1'b0;
      spi_wr_addr  <= '0;
    end else begin
      spi_wr_valid <= 1'b0;
      if (state == ST_WAIT_DESEL || deselect) begin
        bit_cnt <= '0;
        shift   <= '0;
        miso_q  <= 1'b0;
      end else begin
        if (rise && (state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_WR})) begin
          shift   <= in_byte[6:0];
          bit_cnt <= (cmd_done || addr_done || dummy_done || commit) ? 5'd0 : bit_cnt + 5'd1;
        end
        if (cmd_done) begin
          cmd    <= in_byte;
          tx_sh  <= {7'b0, dirty};
          tx_cnt <= '0;
        end
        // Only the low address bits reach the pointer; upper address bytes drop out.
        if (addr_done) begin
          ptr    <= in_byte[RAM_LEN_BITS-1:0];
          tx_sh  <= mem[in_byte[RAM_LEN_BITS-1:0]];
          tx_cnt <= '0;
        end
        if (dummy_done) begin
          tx_sh  <= mem[ptr];
          tx_cnt <= '0;
        end
        if (commit) begin
          spi_wr_valid <= 1'b1;
          spi_wr_addr  <= ptr;
          ptr          <= ptr_inc;
        end
        // Bit 7 of a byte goes out on the fall after the byte is loaded; the
        // next byte is fetched as bit 0 leaves, so the stream has no gap.
        if (state_next != state) begin
          miso_q <= 1'b0;
        end else if (fall && (state == ST_RD || state == ST_STATUS)) begin
          miso_q <= tx_sh[7];
          tx_cnt <= tx_cnt + 3'd1;
          if (tx_cnt == 3'd7) begin
            if (state == ST_RD) begin
              tx_sh <= mem[ptr_inc];
              ptr   <= ptr_inc;
            end else begin
              tx_sh <= {7'b0, dirty};
            end
          end else begin
            tx_sh <= {tx_sh[6:0], 1'b0};
          end
        end
      end
    end
  end

  // SPI commit is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[RAM_LEN_BITS'(i)] <= '0;
      byte_out <= '0;
    end else begin
      byte_out <= mem[addr_in];
      if (wr_en)  mem[addr_in] <= data_in;
      if (commit) mem[ptr]     <= in_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)           dirty <= 1'b0;
    else if (commit)      dirty <= 1'b1;
    else if (clear_dirty) dirty <= 1'b0;
  end

  assign spi_miso = miso_q;

endmodule

// File: tb/tb_spi_ram_sync.sv
// Bench for spi_ram_sync: a bit-banged SPI master and host-port tasks push
// expected responses; monitors pop and compare when the DUT produces output.
module tb_spi_ram_sync;

  localparam int RLB = 5;
  localparam int PH  = 5;

  logic           clk;
  logic           rst_n;
  logic           spi_clk;
  logic           spi_mosi;
  logic           spi_select;
  logic           spi_miso;
  logic [RLB-1:0] addr_in;
  logic [7:0]     byte_out;
  logic           wr_en;
  logic [7:0]     data_in;
  logic           clear_dirty;
  logic           spi_wr_valid;
  logic [RLB-1:0] spi_wr_addr;
  logic           dirty;

  spi_ram_sync #(.RAM_LEN_BITS(RLB), .ADDR_BYTES(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_select   (spi_select),
    .spi_miso     (spi_miso),
    .addr_in      (addr_in),
    .byte_out     (byte_out),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .clear_dirty  (clear_dirty),
    .spi_wr_valid (spi_wr_valid),
    .spi_wr_addr  (spi_wr_addr),
    .dirty        (dirty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, test did not complete");
    $fatal(1);
  end

  // scoreboard state
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [7:0]     exp_rx_q[$];
  logic [RLB-1:0] exp_wr_q[$];
  logic [7:0]     exp_rd_q[$];
  logic [0:0]     exp_lvl_q[$];
  logic [7:0]     rx_byte;
  logic [7:0]     rx_exp;
  logic [RLB-1:0] wr_exp;
  logic [7:0]     rd_exp;
  logic [0:0]     lvl_exp;
  logic           rd_req  = 1'b0;
  logic           rd_pend = 1'b0;
  logic           lvl_req = 1'b0;
  logic           lvl_sel = 1'b0;
  event           rx_ev;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, input bit chk);
    logic [7:0] rx;
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      tick(PH);
      spi_clk = 1'b1;
      rx[i]   = spi_miso;
      tick(PH);
      spi_clk = 1'b0;
    end
    spi_mosi = 1'b0;
    if (chk) begin
      rx_byte = rx;
      -> rx_ev;
    end
  endtask

  task automatic spi_send(input logic [7:0] tx, input logic [7:0] exp);
    exp_rx_q.push_back(exp);
    spi_bits(tx, 8, 1'b1);
  endtask

  task automatic spi_start();
    spi_select = 1'b0;
    tick(PH);
  endtask

  task automatic spi_stop();
    tick(PH);
    spi_select = 1'b1;
    tick(2 * PH);
  endtask

  task automatic host_write(input logic [RLB-1:0] a, input logic [7:0] d);
    addr_in = a;
    data_in = d;
    wr_en   = 1'b1;
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic host_read(input logic [RLB-1:0] a, input logic [7:0] exp);
    addr_in = a;
    exp_rd_q.push_back(exp);
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
  endtask

  // sel 0 probes spi_miso, sel 1 probes dirty
  task automatic probe(input logic sel, input logic exp);
    exp_lvl_q.push_back(exp);
    lvl_sel = sel;
    lvl_req = 1'b1;
    tick(1);
    lvl_req = 1'b0;
  endtask

  // monitors
  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (spi_wr_valid) begin
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_pulse: unexpected spi_wr_valid, addr got %0d, none required", spi_wr_addr);
      end else begin
        wr_exp = exp_wr_q.pop_front();
        if (spi_wr_addr !== wr_exp) begin
          n_fail++;
          $display("FAIL wr_addr: got %0d, required %0d", spi_wr_addr, wr_exp);
        end
      end
    end
    if (rd_pend) begin
      n_checks++;
      rd_exp = exp_rd_q.pop_front();
      if (byte_out !== rd_exp) begin
        n_fail++;
        $display("FAIL byte_out: addr %0d got %02h, required %02h", addr_in, byte_out, rd_exp);
      end
    end
    if (lvl_req) begin
      n_checks++;
      lvl_exp = exp_lvl_q.pop_front();
      if ((lvl_sel ? dirty : spi_miso) !== lvl_exp[0]) begin
        n_fail++;
        $display("FAIL %s: got %b, required %b", lvl_sel ? "dirty" : "miso_level",
                 lvl_sel ? dirty : spi_miso, lvl_exp[0]);
      end
    end
  end

  always @(rx_ev) begin
    n_checks++;
    if (exp_rx_q.size() == 0) begin
      n_fail++;
      $display("FAIL miso_byte: got %02h with no expected byte queued", rx_byte);
    end else begin
      rx_exp = exp_rx_q.pop_front();
      if (rx_byte !== rx_exp) begin
        n_fail++;
        $display("FAIL miso_byte: got %02h, required %02h", rx_byte, rx_exp);
      end
    end
  end

  // stimulus
  initial begin
    rst_n       = 1'b0;
    spi_clk     = 1'b0;
    spi_mosi    = 1'b0;
    spi_select  = 1'b1;
    addr_in     = '0;
    wr_en       = 1'b0;
    data_in     = '0;
    clear_dirty = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(4);

    // reset state
    probe(1'b0, 1'b0);
    probe(1'b1, 1'b0);
    host_read(5'd3, 8'h00);

    // host port write then read back
    host_write(5'd3, 8'hA5);
    host_read(5'd3, 8'hA5);

    // SPI write of two bytes from address 2
    exp_wr_q.push_back(5'd2);
    exp_wr_q.push_back(5'd3);
    spi_start();
    spi_send(8'h02, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h02, 8'h00);
    spi_send(8'h11, 8'h00);
    spi_send(8'h22, 8'h00);
    spi_stop();
    host_read(5'd2, 8'h11);
    host_read(5'd3, 8'h22);
    probe(1'b1, 1'b1);

    // read across the top of RAM wraps to address 0
    host_write(5'd31, 8'hC3);
    host_write(5'd0, 8'h3C);
    spi_start();
    spi_send(8'h03, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h1F, 8'h00);
    spi_send(8'h00, 8'hC3);
    spi_send(8'h00, 8'h3C);
    spi_stop();

    // fast read: dummy byte returns zeros
    spi_start();
    spi_send(8'h0B, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h02, 8'h00);
    spi_send(8'hFF, 8'h00);
    spi_send(8'h00, 8'h11);
    spi_send(8'h00, 8'h22);
    spi_stop();

    // status with dirty set, then cleared
    spi_start();
    spi_send(8'h05, 8'h00);
    spi_send(8'h00, 8'h01);
    spi_send(8'h00, 8'h01);
    spi_stop();
    clear_dirty = 1'b1;
    tick(1);
    clear_dirty = 1'b0;
    probe(1'b1, 1'b0);
    spi_start();
    spi_send(8'h05, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_stop();

    // unknown command: silent, no RAM change
    spi_start();
    spi_send(8'h9F, 8'h00);
    spi_send(8'h02, 8'h00);
    spi_send(8'h55, 8'h00);
    spi_stop();
    host_read(5'd2, 8'h11);
    host_read(5'd0, 8'h3C);

    // SPI write wrapping from 31 to 0
    exp_wr_q.push_back(5'd31);
    exp_wr_q.push_back(5'd0);
    spi_start();
    spi_send(8'h02, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h1F, 8'h00);
    spi_send(8'hAA, 8'h00);
    spi_send(8'hBB, 8'h00);
    spi_stop();
    host_read(5'd31, 8'hAA);
    host_read(5'd0, 8'hBB);
    probe(1'b1, 1'b1);

    // partial write byte is discarded
    spi_start();
    spi_send(8'h02, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_bits(8'hFF, 5, 1'b0);
    spi_stop();
    host_read(5'd0, 8'hBB);

    // reset in the middle of a read while spi_miso is high
    spi_start();
    spi_send(8'h03, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h1F, 8'h00);
    spi_bits(8'h00, 2, 1'b0);
    tick(PH);
    probe(1'b0, 1'b1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    probe(1'b0, 1'b0);
    probe(1'b1, 1'b0);
    host_write(5'd3, 8'h5A);
    // select still low: a complete read must be ignored
    spi_send(8'h03, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h03, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_stop();
    spi_start();
    spi_send(8'h03, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h00, 8'h00);
    spi_send(8'h03, 8'h00);
    spi_send(8'h00, 8'h5A);
    spi_stop();
    host_read(5'd31, 8'h00);
    host_read(5'd3, 8'h5A);

    // final report
    tick(20);
    n_checks++;
    if (exp_rx_q.size() != 0 || exp_wr_q.size() != 0 ||
        exp_rd_q.size() != 0 || exp_lvl_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: left rx=%0d wr=%0d rd=%0d lvl=%0d, required all 0",
               exp_rx_q.size(), exp_wr_q.size(), exp_rd_q.size(), exp_lvl_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_sync.md
# spi_ram_sync

Parametrised SPI-mode-0 RAM peripheral that runs entirely in the system clock domain: the SPI pins are oversampled and edge-detected instead of clocking logic. It accepts read (03h), fast read (0Bh), write (02h) and read-status (05h) commands, with configurable RAM depth and address width. The system side has a registered read port, a write port and a write-notification strobe. It sits between the chip's SPI pins and design logic that consumes or produces the RAM bytes.

## Interface
- RAM_LEN_BITS, 5, log2 of RAM depth in bytes (2..8)
- ADDR_BYTES, 3, address bytes following the command (1..3)
- clk  in  1  system clock; must be at least 4x spi_clk frequency
- rst_n  in  1  synchronous active-low reset
- spi_clk  in  1  SPI clock, mode 0 (idle low, sample on rise, shift on fall); asynchronous
- spi_mosi  in  1  SPI data in, MSB first; asynchronous
- spi_select  in  1  chip select, active low; asynchronous
- spi_miso  out  1  SPI data out; 0 whenever not in a read or status data phase
- addr_in  in  RAM_LEN_BITS  system read/write address
- byte_out  out  8  registered RAM[addr_in]
- wr_en  in  1  system write strobe
- data_in  in  8  system write data
- clear_dirty  in  1  clears status dirty bit
- spi_wr_valid  out  1  one-cycle pulse when an SPI write commits a byte
- spi_wr_addr  out  RAM_LEN_BITS  address of the committed byte, valid with spi_wr_valid
- dirty  out  1  status bit 0: set by any SPI byte commit

## Operation
- Synchronisers: 2-flop synchronisers on spi_clk, spi_mosi and spi_select. Reset values: spi_clk 0, spi_select 1, spi_mosi 0. A third registered copy of spi_clk gives rise/fall detect pulses. spi_mosi is sampled on the detected rise from its synchronised copy.
- Deselect (synchronised select = 1) forces state CMD, clears the bit counter and clears the shift register, regardless of state.
- States:
  - WAIT_DESEL: entered from reset. Exits to CMD only after select is seen high.
  - CMD: collect 8 bits, then branch on the command byte:
    - 03h/02h/0Bh -> ADDR
    - 05h -> STATUS
    - anything else -> IGNORE
  - ADDR: collect ADDR_BYTES*8 bits; only the low RAM_LEN_BITS form the pointer and the upper bits are ignored. Then 0Bh -> DUMMY, 03h -> RD, 02h -> WR.
  - DUMMY: 8 rises ignored, then -> RD.
  - RD: shift RAM[ptr] MSB-first. The pointer increments after each 8th bit and wraps to 0 at 2**RAM_LEN_BITS.
  - WR: collect 8 bits. On the 8th rise, commit the byte to RAM[ptr], pulse spi_wr_valid with spi_wr_addr = ptr, set dirty, then increment the pointer with wrap.
  - STATUS: shift {7'b0, dirty} repeatedly until deselect.
  - IGNORE: miso 0 until deselect.
- A partial write byte at deselect is discarded: no commit, no pulse.
- MISO: the output bit is registered and updates only on a detected fall or on a state entry.
  - RD/STATUS: the first data bit (bit 7) is driven on the fall following the last address, dummy or command bit.
  - The next byte is fetched from RAM when bit 0 is shifted out.
- System port: byte_out <= RAM[addr_in] every cycle. wr_en writes data_in to RAM[addr_in].
- Same-cycle collisions:
  - SPI commit and wr_en to the same address: the SPI data wins.
  - Different addresses: both writes take effect.
  - clear_dirty in the same cycle as an SPI commit: dirty ends at 1.
- Reset clears all RAM bytes to 00h, dirty to 0, pointer to 0, byte_out to 00h, spi_miso to 0, spi_wr_valid to 0 and spi_wr_addr to 0. State goes to WAIT_DESEL.

## Timing
- SPI pin edge to internal detect pulse: 3 clk cycles. Detected fall to spi_miso change: 1 further clk cycle, so spi_miso changes 4 clk after the pin fall.
- Minimum clk/spi_clk ratio is 4, and each SPI clock phase must last at least 2 clk cycles. The bench must not violate this.
- spi_wr_valid is asserted for exactly one clk, in the cycle after the 8th-bit rise is detected. The RAM write lands in that same cycle.
- byte_out latency is 1 clk from addr_in, and it reflects RAM contents before any write in the same cycle.
- dirty is updated together with spi_wr_valid and cleared 1 clk after clear_dirty.
- Pointer wrap: after byte 2**RAM_LEN_BITS-1 the next byte is 0, with no gap in the bitstream.
- rst_n low mid-transaction aborts it with no commit. The block then ignores SPI activity until a deselect.

## Test plan
- Reset, then host writes RAM[3]=A5h via wr_en -> byte_out = A5h one cycle after addr_in=3.
- SPI 02h, addr 000002h, data 11h 22h -> two spi_wr_valid pulses with spi_wr_addr 2 then 3; byte_out 11h at addr 2 and 22h at addr 3; dirty=1.
- SPI 03h, addr 00001Fh (RAM_LEN_BITS=5), read 2 bytes after RAM[31]=C3h and RAM[0]=3Ch -> MISO returns C3h then 3Ch (wrap).
- SPI 0Bh, addr 000002h, 8 dummy bits -> MISO returns 11h; MISO is 0 during the dummy bits.
- SPI 05h after a write -> MISO 01h; assert clear_dirty and repeat -> 00h. Command 9Fh -> MISO 00h and no RAM change.
- Write of 02h, addr 0, followed by 5 bits then deselect -> no spi_wr_valid, RAM[0] unchanged. Asserting rst_n mid-read -> spi_miso 0; the next transaction is accepted only after select goes high.
